// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Single-issue instruction decoder. It uses a valid/ready handshake on both
//   sides and has one register stage. An accepted instruction is decoded into
//   a control bundle, and that bundle appears one cycle later with out_valid
//   set. A halt instruction parks the stage in HALTED until resume is pulsed.
//
//   Optional feature (macro DECODE_ILLEGAL_TRAP_EN):
//     When the macro is defined, opcodes above the last defined opcode still
//     decode as a NOP. They also set the sticky 'illegal' flag and park the
//     stage in HALTED. Resume clears 'illegal'.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake; instr is the instruction word
//   flush             drops the held bundle and blocks acceptance this cycle
//   resume            leaves HALTED (ignored while running)
//   out_valid/out_ready downstream handshake for the bundle below
//   rd0, rd1, wr_reg  register indices (zero-extended fields or specials)
//   alu_op            ALU / branch-compare selector
//   reg_write .. halt single-bit control flags
//   halted            stage is in HALTED
//   decode_count      count of accepted instructions (wraps)
//   illegal           sticky illegal-opcode flag (only with the macro)
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int INSTR_W = 9,
  parameter int OPC_W   = 5,
  parameter int RFLD_W  = 2,
  parameter int RIDX_W  = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic              flush,
  input  logic              resume,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [RIDX_W-1:0] rd0,
  output logic [RIDX_W-1:0] rd1,
  output logic [RIDX_W-1:0] wr_reg,
  output logic [3:0]        alu_op,
  output logic              reg_write,
  output logic              move,
  output logic              mem_to_reg,
  output logic              mem_write,
  output logic              branch,
  output logic              jump_sign,
  output logic              immediate,
  output logic              set_quarter,
  output logic              halt,
  output logic              halted,
  output logic [CNT_W-1:0]  decode_count
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // Special register indices
  localparam logic [RIDX_W-1:0] R_ADR  = RIDX_W'(4);
  localparam logic [RIDX_W-1:0] R_MATH = RIDX_W'(5);
  localparam logic [RIDX_W-1:0] R_CNT  = RIDX_W'(7);

  localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_MV     = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SETADR = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_MVADR  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_RSADR  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SETI   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_MVMATH = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_TOMATH = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_M2ADR  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_SETREG = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_SETCNT = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_MVCNT  = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_TOCNT  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_RSCNT  = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_BE     = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_BNE    = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_BEZ    = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_BLTZ   = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_BGTE   = OPC_W'(19);
  localparam logic [OPC_W-1:0] OP_EVU    = OPC_W'(20);
  localparam logic [OPC_W-1:0] OP_EVL    = OPC_W'(21);
  localparam logic [OPC_W-1:0] OP_LD     = OPC_W'(22);
  localparam logic [OPC_W-1:0] OP_ST     = OPC_W'(23);
  localparam logic [OPC_W-1:0] OP_JUMP   = OPC_W'(24);
  localparam logic [OPC_W-1:0] OP_ZERO   = OPC_W'(25);
  localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(26);

  typedef struct packed {
    logic [RIDX_W-1:0] rd0;
    logic [RIDX_W-1:0] rd1;
    logic [RIDX_W-1:0] wr_reg;
    logic [3:0]        alu_op;
    logic              reg_write;
    logic              move;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch;
    logic              jump_sign;
    logic              immediate;
    logic              set_quarter;
    logic              halt;
  } bundle_t;

  logic [OPC_W-1:0]  opc_s;
  logic [RIDX_W-1:0] fa_s;
  logic [RIDX_W-1:0] fb_s;
  logic [RIDX_W-1:0] imm_s;
  bundle_t           dec_s;
  bundle_t           bundle_r;
  logic              out_valid_r;
  logic [0:0]        state_r;
  logic [CNT_W-1:0]  count_r;
  logic              accept_s;
  logic              park_s;

  assign opc_s = instr[INSTR_W-1 -: OPC_W];
  assign fa_s  = RIDX_W'(instr[2*RFLD_W-1:RFLD_W]);
  assign fb_s  = RIDX_W'(instr[RFLD_W-1:0]);
  assign imm_s = RIDX_W'(instr[2*RFLD_W-1:0]);

  assign in_ready = (state_r == ST_RUN) && (!out_valid_r || out_ready) && !flush;
  assign accept_s = in_valid && in_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_op_s;
  logic illegal_r;
  assign illegal_op_s = (opc_s > OP_HALT);
  assign park_s       = dec_s.halt || illegal_op_s;
  assign illegal      = illegal_r;
`else
  assign park_s = dec_s.halt;
`endif

  // Combinational opcode decode; every field not set by an opcode stays zero
  always_comb begin
    dec_s = '0;
    case (opc_s)
      OP_ADD:    begin dec_s.rd0 = fa_s; dec_s.rd1 = R_MATH; dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.alu_op = 4'd0; end
      OP_SUB:    begin dec_s.rd0 = fa_s; dec_s.rd1 = R_MATH; dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.alu_op = 4'd1; end
      OP_MV:     begin dec_s.rd0 = fa_s; dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.move = 1'b1; end
      OP_SETADR: begin dec_s.rd0 = fa_s; dec_s.wr_reg = R_ADR; dec_s.reg_write = 1'b1; dec_s.move = 1'b1; end
      OP_MVADR:  begin dec_s.rd0 = R_ADR; dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.move = 1'b1; end
      OP_RSADR:  begin dec_s.wr_reg = R_ADR; dec_s.reg_write = 1'b1; dec_s.immediate = 1'b1; dec_s.jump_sign = instr[0]; end
      OP_SETI:   begin dec_s.rd0 = imm_s; dec_s.wr_reg = R_MATH; dec_s.reg_write = 1'b1; dec_s.immediate = 1'b1; end
      OP_MVMATH: begin dec_s.rd0 = R_MATH; dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.move = 1'b1; end
      OP_TOMATH: begin dec_s.rd0 = fa_s; dec_s.wr_reg = R_MATH; dec_s.reg_write = 1'b1; dec_s.move = 1'b1; end
      OP_M2ADR:  begin dec_s.rd0 = R_MATH; dec_s.rd1 = fa_s; dec_s.wr_reg = R_ADR; dec_s.reg_write = 1'b1; dec_s.move = 1'b1; dec_s.set_quarter = 1'b1; end
      OP_SETREG: begin dec_s.rd0 = R_MATH; dec_s.rd1 = fa_s; dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.move = 1'b1; dec_s.set_quarter = 1'b1; end
      OP_SETCNT: begin dec_s.rd0 = fb_s; dec_s.rd1 = fa_s; dec_s.wr_reg = R_CNT; dec_s.reg_write = 1'b1; dec_s.move = 1'b1; dec_s.set_quarter = 1'b1; end
      OP_MVCNT:  begin dec_s.rd0 = R_CNT; dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.move = 1'b1; end
      OP_TOCNT:  begin dec_s.rd0 = fa_s; dec_s.wr_reg = R_CNT; dec_s.reg_write = 1'b1; dec_s.move = 1'b1; end
      OP_RSCNT:  begin dec_s.wr_reg = R_CNT; dec_s.reg_write = 1'b1; dec_s.immediate = 1'b1; end
      OP_BE:     begin dec_s.rd0 = fa_s; dec_s.rd1 = fb_s; dec_s.branch = 1'b1; dec_s.alu_op = 4'd7; end
      OP_BNE:    begin dec_s.rd0 = fa_s; dec_s.rd1 = fb_s; dec_s.branch = 1'b1; dec_s.alu_op = 4'd8; end
      OP_BEZ:    begin dec_s.rd0 = fa_s; dec_s.rd1 = fb_s; dec_s.branch = 1'b1; dec_s.alu_op = 4'd6; end
      OP_BLTZ:   begin dec_s.rd0 = fa_s; dec_s.rd1 = fb_s; dec_s.branch = 1'b1; dec_s.alu_op = 4'd5; end
      OP_BGTE:   begin dec_s.rd0 = fa_s; dec_s.rd1 = fb_s; dec_s.branch = 1'b1; dec_s.alu_op = 4'd4; end
      OP_EVU:    begin dec_s.rd0 = fa_s; dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.alu_op = 4'd2; end
      OP_EVL:    begin dec_s.rd0 = fa_s; dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.alu_op = 4'd3; end
      OP_LD:     begin dec_s.rd0 = fa_s; dec_s.rd1 = R_ADR; dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.mem_to_reg = 1'b1; end
      OP_ST:     begin dec_s.rd0 = fa_s; dec_s.rd1 = R_ADR; dec_s.mem_write = 1'b1; end
      OP_JUMP:   begin dec_s.branch = 1'b1; dec_s.alu_op = 4'd7; end
      OP_ZERO:   begin dec_s.wr_reg = fb_s; dec_s.reg_write = 1'b1; dec_s.immediate = 1'b1; end
      OP_HALT:   begin dec_s.halt = 1'b1; end
      default:   begin dec_s = '0; end
    endcase
  end

  // Output register: load on accept, hold under backpressure, drop on flush/drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      bundle_r    <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      bundle_r    <= dec_s;
    end else if (flush || out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // RUN/HALTED control; flush never changes state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:    if (accept_s && park_s) state_r <= ST_HALTED;
        ST_HALTED: if (resume) state_r <= ST_RUN;
        default:   state_r <= ST_RUN;
      endcase
    end
  end

  // Accepted-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (accept_s) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by leaving HALTED via resume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else if ((state_r == ST_HALTED) && resume) begin
      illegal_r <= 1'b0;
    end else if (accept_s && illegal_op_s) begin
      illegal_r <= 1'b1;
    end
  end
`endif

  assign out_valid    = out_valid_r;
  assign rd0          = bundle_r.rd0;
  assign rd1          = bundle_r.rd1;
  assign wr_reg       = bundle_r.wr_reg;
  assign alu_op       = bundle_r.alu_op;
  assign reg_write    = bundle_r.reg_write;
  assign move         = bundle_r.move;
  assign mem_to_reg   = bundle_r.mem_to_reg;
  assign mem_write    = bundle_r.mem_write;
  assign branch       = bundle_r.branch;
  assign jump_sign    = bundle_r.jump_sign;
  assign immediate    = bundle_r.immediate;
  assign set_quarter  = bundle_r.set_quarter;
  assign halt         = bundle_r.halt;
  assign halted       = (state_r == ST_HALTED);
  assign decode_count = count_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (CNT_W=4 so the counter wrap is reachable).
module tb_decode_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] instr;
  logic       flush;
  logic       resume;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] rd0, rd1, wr_reg, alu_op;
  logic       reg_write, move, mem_to_reg, mem_write, branch;
  logic       jump_sign, immediate, set_quarter, halt, halted;
  logic [3:0] decode_count;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0]  exp_cnt;
  logic [24:0] obs;
  logic [8:0]  vi [13];
  logic [24:0] ve [13];

  localparam logic [8:0] F_RW  = 9'b100000000;
  localparam logic [8:0] F_MV  = 9'b010000000;
  localparam logic [8:0] F_M2R = 9'b001000000;
  localparam logic [8:0] F_MW  = 9'b000100000;
  localparam logic [8:0] F_BR  = 9'b000010000;
  localparam logic [8:0] F_JS  = 9'b000001000;
  localparam logic [8:0] F_IMM = 9'b000000100;
  localparam logic [8:0] F_SQ  = 9'b000000010;
  localparam logic [8:0] F_HLT = 9'b000000001;

  decode_stage #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .resume(resume), .out_ready(out_ready),
    .out_valid(out_valid), .rd0(rd0), .rd1(rd1), .wr_reg(wr_reg),
    .alu_op(alu_op), .reg_write(reg_write), .move(move),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .branch(branch),
    .jump_sign(jump_sign), .immediate(immediate), .set_quarter(set_quarter),
    .halt(halt), .halted(halted), .decode_count(decode_count)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  assign obs = {rd0, rd1, wr_reg, alu_op, reg_write, move, mem_to_reg,
                mem_write, branch, jump_sign, immediate, set_quarter, halt};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] mk(input logic [4:0] op, input logic [1:0] a, input logic [1:0] b);
    return {op, a, b};
  endfunction

  function automatic logic [24:0] bnd(input logic [3:0] r0, input logic [3:0] r1,
                                      input logic [3:0] wr, input logic [3:0] alu,
                                      input logic [8:0] fl);
    return {r0, r1, wr, alu, fl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, o, e);
    end
  endtask

  task automatic chkc(input string tag, input logic [3:0] o, input logic [3:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic chkb(input string tag, input logic [24:0] o, input logic [24:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%07h expected=%07h", tag, o, e);
    end
  endtask

  initial begin
    vi[0]  = mk(5'd1, 2'd3, 2'd1);  ve[0]  = bnd(4'd3, 4'd5, 4'd1, 4'd1, F_RW);               // sub
    vi[1]  = mk(5'd6, 2'd2, 2'd3);  ve[1]  = bnd(4'd11, 4'd0, 4'd5, 4'd0, F_RW | F_IMM);      // seti 1011
    vi[2]  = mk(5'd16, 2'd2, 2'd3); ve[2]  = bnd(4'd2, 4'd3, 4'd0, 4'd8, F_BR);               // bne
    vi[3]  = mk(5'd22, 2'd1, 2'd0); ve[3]  = bnd(4'd1, 4'd4, 4'd0, 4'd0, F_RW | F_M2R);       // ld
    vi[4]  = mk(5'd11, 2'd1, 2'd2); ve[4]  = bnd(4'd2, 4'd1, 4'd7, 4'd0, F_RW | F_MV | F_SQ); // setCnt
    vi[5]  = mk(5'd5, 2'd0, 2'd1);  ve[5]  = bnd(4'd0, 4'd0, 4'd4, 4'd0, F_RW | F_IMM | F_JS); // rsAdr, sign 1
    vi[6]  = mk(5'd25, 2'd2, 2'd3); ve[6]  = bnd(4'd0, 4'd0, 4'd3, 4'd0, F_RW | F_IMM);      // zeroReg
    vi[7]  = mk(5'd21, 2'd1, 2'd2); ve[7]  = bnd(4'd1, 4'd0, 4'd2, 4'd3, F_RW);               // evl
    vi[8]  = mk(5'd9, 2'd2, 2'd0);  ve[8]  = bnd(4'd5, 4'd2, 4'd4, 4'd0, F_RW | F_MV | F_SQ); // mathToAdr
    vi[9]  = mk(5'd24, 2'd3, 2'd3); ve[9]  = bnd(4'd0, 4'd0, 4'd0, 4'd7, F_BR);               // jump
    vi[10] = mk(5'd19, 2'd1, 2'd3); ve[10] = bnd(4'd1, 4'd3, 4'd0, 4'd4, F_BR);               // bgte
    vi[11] = mk(5'd12, 2'd3, 2'd1); ve[11] = bnd(4'd7, 4'd0, 4'd1, 4'd0, F_RW | F_MV);        // mvCnt
    vi[12] = mk(5'd5, 2'd1, 2'd2);  ve[12] = bnd(4'd0, 4'd0, 4'd4, 4'd0, F_RW | F_IMM);      // rsAdr, sign 0

    rst = 1'b1; in_valid = 1'b0; instr = 9'd0; flush = 1'b0; resume = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk1("rst_valid", out_valid, 1'b0);
    chkb("rst_bundle", obs, 25'd0);
    chkc("rst_cnt", decode_count, 4'd0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    #2 rst = 1'b0;

    // add a=1 b=2
    instr = 9'b000000110; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; exp_cnt = 4'd1;
    chk1("add_valid", out_valid, 1'b1);
    chkb("add_bundle", obs, bnd(4'd1, 4'd5, 4'd2, 4'd0, F_RW));
    chkc("add_cnt", decode_count, exp_cnt);
    tick();
    chk1("drain_valid", out_valid, 1'b0);

    // back-to-back decode table, one per cycle
    for (int i = 0; i < 13; i++) begin
      instr = vi[i]; in_valid = 1'b1;
      chk1("tbl_ready", in_ready, 1'b1);
      tick();
      exp_cnt++;
      chk1("tbl_valid", out_valid, 1'b1);
      chkb("tbl_bundle", obs, ve[i]);
      chkc("tbl_cnt", decode_count, exp_cnt);
    end
    in_valid = 1'b0;
    tick();

    // st a=3 held under backpressure
    out_ready = 1'b0; instr = mk(5'd23, 2'd3, 2'd0); in_valid = 1'b1;
    tick();
    exp_cnt++;
    chkb("st_bundle", obs, bnd(4'd3, 4'd4, 4'd0, 4'd0, F_MW));
    instr = mk(5'd0, 2'd1, 2'd2);
    for (int i = 0; i < 3; i++) begin
      chk1("bp_ready", in_ready, 1'b0);
      tick();
      chk1("bp_valid", out_valid, 1'b1);
      chkb("bp_hold", obs, bnd(4'd3, 4'd4, 4'd0, 4'd0, F_MW));
      chkc("bp_cnt", decode_count, exp_cnt);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk1("bp_drain", out_valid, 1'b0);

    // flush with a held bundle and a pending instruction
    out_ready = 1'b0; instr = mk(5'd2, 2'd1, 2'd3); in_valid = 1'b1;
    tick();
    exp_cnt++;
    chkb("mv_bundle", obs, bnd(4'd1, 4'd0, 4'd3, 4'd0, F_RW | F_MV));
    flush = 1'b1; out_ready = 1'b1; instr = mk(5'd0, 2'd1, 2'd2);
    chk1("fl_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk1("fl_valid", out_valid, 1'b0);
    chkc("fl_cnt", decode_count, exp_cnt);
    chk1("fl_halted", halted, 1'b0);

    // resume while running is ignored
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk1("res_run_halted", halted, 1'b0);
    chk1("res_run_ready", in_ready, 1'b1);

    // halt, then resume
    instr = mk(5'd26, 2'd0, 2'd0); in_valid = 1'b1;
    tick();
    exp_cnt++;
    chkb("halt_bundle", obs, bnd(4'd0, 4'd0, 4'd0, 4'd0, F_HLT));
    chk1("halt_halted", halted, 1'b1);
    chk1("halt_ready", in_ready, 1'b0);
    tick();
    chkc("halt_cnt", decode_count, exp_cnt);
    chk1("halt_drain", out_valid, 1'b0);
    in_valid = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0;
    chk1("resume_ready", in_ready, 1'b1);
    chk1("resume_halted", halted, 1'b0);

    // opcode 28
    instr = mk(5'd28, 2'd1, 2'd2); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; exp_cnt++;
    chk1("ill_valid", out_valid, 1'b1);
    chkb("ill_bundle", obs, 25'd0);
    chkc("ill_cnt", decode_count, exp_cnt);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk1("ill_flag", illegal, 1'b1);
    chk1("ill_halted", halted, 1'b1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk1("ill_clear", illegal, 1'b0);
    chk1("ill_resumed", halted, 1'b0);
`else
    chk1("ill_halted", halted, 1'b0);
    chk1("ill_ready", in_ready, 1'b1);
`endif
    tick();

    // asynchronous reset while a bundle is held
    out_ready = 1'b0; instr = mk(5'd0, 2'd1, 2'd2); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("pre_rst_valid", out_valid, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk1("arst_valid", out_valid, 1'b0);
    chkb("arst_bundle", obs, 25'd0);
    chkc("arst_cnt", decode_count, 4'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1; exp_cnt = 4'd0;

    // 17 acceptances on a 4-bit counter
    instr = mk(5'd2, 2'd0, 2'd1); in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      exp_cnt++;
      chkc("wrap_cnt", decode_count, exp_cnt);
    end
    in_valid = 1'b0;
    chkc("wrap_final", decode_count, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
